// File: rtl/ika_video_timing.sv
// ika_video_timing -- parametrised raster timing generator.
// Divides the master clock into a one-cycle pixel enable and produces the
// H/V counters, active-low sync and blanking. Frame totals are selectable
// (original, NTSC-friendly, custom-adjusted) and the vertical sync position
// can be shifted by -7..+7 lines. Mode, adjust and VPOS inputs are sampled
// only at the frame boundary so a frame never changes shape part-way through.
// Optional feature: define IKA_VTIMING_FRAMECNT_EN to build the 16-bit frame
// counter; otherwise o_FRAMECNT is tied to zero.
module ika_video_timing #(
  parameter int PXCEN_DIV    = 10,
  parameter int CNT_W        = 9,
  parameter int H_TOTAL      = 384,
  parameter int H_ACTIVE     = 256,
  parameter int H_SYNC_START = 296,
  parameter int H_SYNC_LEN   = 32,
  parameter int V_TOTAL      = 264,
  parameter int V_ACTIVE     = 224,
  parameter int V_SYNC_START = 240,
  parameter int V_SYNC_LEN   = 8,
  parameter int H_TOTAL_NTSC = 384,
  parameter int V_TOTAL_NTSC = 262
) (
  input  logic             i_EMU_MCLK,
  input  logic             i_EMU_INITRST_n,
  input  logic [1:0]       i_MODE,
  input  logic [1:0]       i_ADJ_H,
  input  logic [2:0]       i_ADJ_V,
  input  logic [3:0]       i_VPOS,
  output logic             o_PXCEN,
  output logic [CNT_W-1:0] o_HCNT,
  output logic [CNT_W-1:0] o_VCNT,
  output logic             o_HSYNC_n,
  output logic             o_VSYNC_n,
  output logic             o_HBLANK_n,
  output logic             o_VBLANK_n,
  output logic [15:0]      o_FRAMECNT
);

  localparam int DIV_W = $clog2(PXCEN_DIV);
  localparam int TW    = CNT_W + 1;   // totals need one bit more than counters
  localparam int VW    = CNT_W + 3;   // headroom for sync-start + vtot + offset

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PXCEN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(PXCEN_DIV - 2);

  localparam logic [TW-1:0] H_ACT_T = TW'(H_ACTIVE);
  localparam logic [TW-1:0] HS_LO   = TW'(H_SYNC_START);
  localparam logic [TW-1:0] HS_HI   = TW'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [TW-1:0] V_ACT_T = TW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_LEN  = VW'(V_SYNC_LEN);

  // Horizontal total for a given mode/adjust pair; mode 3 falls back to original.
  function automatic logic [TW-1:0] calc_htot(input logic [1:0] mode, input logic [1:0] adj);
    logic [TW-1:0] t;
    case (mode)
      2'd1:    t = TW'(H_TOTAL_NTSC);
      2'd2:    t = TW'(H_TOTAL) + TW'({adj, 1'b0});
      default: t = TW'(H_TOTAL);
    endcase
    return t;
  endfunction

  // Vertical total for a given mode/adjust pair.
  function automatic logic [TW-1:0] calc_vtot(input logic [1:0] mode, input logic [2:0] adj);
    logic [TW-1:0] t;
    case (mode)
      2'd1:    t = TW'(V_TOTAL_NTSC);
      2'd2:    t = TW'(V_TOTAL) + TW'(adj);
      default: t = TW'(V_TOTAL);
    endcase
    return t;
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       mode_q,  mode_nx;
  logic [1:0]       adj_h_q, adj_h_nx;
  logic [2:0]       adj_v_q, adj_v_nx;
  logic [3:0]       vpos_q,  vpos_nx;
  logic [TW-1:0]    htot, vtot;
  logic             h_last, v_last, frame_wrap;
  logic [CNT_W-1:0] hcnt_nx, vcnt_nx;
  logic [TW-1:0]    hx, vx;
  logic [VW-1:0]    vtot_w, vs_raw, vs_pos, vcnt_w, vs_dist;

  assign htot       = calc_htot(mode_q, adj_h_q);
  assign vtot       = calc_vtot(mode_q, adj_v_q);
  assign h_last     = ({1'b0, o_HCNT} + TW'(1)) >= htot;
  assign v_last     = ({1'b0, o_VCNT} + TW'(1)) >= vtot;
  assign frame_wrap = o_PXCEN && h_last && v_last;

  // Configuration seen by the next frame: live inputs at the wrap, shadows otherwise.
  always_comb begin
    mode_nx  = frame_wrap ? i_MODE  : mode_q;
    adj_h_nx = frame_wrap ? i_ADJ_H : adj_h_q;
    adj_v_nx = frame_wrap ? i_ADJ_V : adj_v_q;
    vpos_nx  = frame_wrap ? i_VPOS  : vpos_q;
  end

  // Next counter values; they only move on the edge that ends a pixel-enable cycle.
  always_comb begin
    hcnt_nx = o_HCNT;
    vcnt_nx = o_VCNT;
    if (o_PXCEN) begin
      if (h_last) begin
        hcnt_nx = '0;
        vcnt_nx = v_last ? '0 : o_VCNT + CNT_W'(1);
      end else begin
        hcnt_nx = o_HCNT + CNT_W'(1);
      end
    end
  end

  // Vsync start line = (V_SYNC_START + offset) mod vtot, and the distance of the
  // next line from it modulo vtot, so the window may wrap into lines 0.. .
  always_comb begin
    vtot_w = VW'(calc_vtot(mode_nx, adj_v_nx));
    vs_raw = VW'(V_SYNC_START) + vtot_w;
    if (vpos_nx != 4'd0) vs_raw = vs_raw + VW'(vpos_nx) - VW'(8);
    vs_pos = vs_raw;
    if (vs_pos >= vtot_w) vs_pos = vs_pos - vtot_w;
    if (vs_pos >= vtot_w) vs_pos = vs_pos - vtot_w;
    vcnt_w  = VW'(vcnt_nx);
    vs_dist = (vcnt_w >= vs_pos) ? (vcnt_w - vs_pos) : (vcnt_w + vtot_w - vs_pos);
  end

  assign hx = {1'b0, hcnt_nx};
  assign vx = {1'b0, vcnt_nx};

  // Pixel divider and registered pixel enable (high while the divider sits at its last count).
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    // NOTE: state uses non-blocking assignments under an async active-low reset so
    // every register samples pre-edge values and clears without waiting for a clock.
    if (!i_EMU_INITRST_n) begin
      div_cnt <= '0;
      o_PXCEN <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      o_PXCEN <= (div_cnt == DIV_PRE);
    end
  end

  // Counters, shadow configuration and decodes, all updated on the same edge.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      o_HCNT     <= '0;
      o_VCNT     <= '0;
      mode_q     <= 2'd0;
      adj_h_q    <= 2'd0;
      adj_v_q    <= 3'd0;
      vpos_q     <= 4'd0;
      o_HSYNC_n  <= 1'b1;
      o_VSYNC_n  <= 1'b1;
      o_HBLANK_n <= 1'b1;
      o_VBLANK_n <= 1'b1;
    end else begin
      o_HCNT     <= hcnt_nx;
      o_VCNT     <= vcnt_nx;
      mode_q     <= mode_nx;
      adj_h_q    <= adj_h_nx;
      adj_v_q    <= adj_v_nx;
      vpos_q     <= vpos_nx;
      // NOTE: decodes are taken from the next counter values so they stay aligned
      // with o_HCNT/o_VCNT instead of lagging one pixel behind.
      o_HBLANK_n <= (hx < H_ACT_T);
      o_VBLANK_n <= (vx < V_ACT_T);
      o_HSYNC_n  <= !((hx >= HS_LO) && (hx < HS_HI));
      o_VSYNC_n  <= !(vs_dist < VS_LEN);
    end
  end

`ifdef IKA_VTIMING_FRAMECNT_EN
  logic [15:0] frame_cnt;

  // Frames completed, wrapping modulo 2^16.
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) frame_cnt <= 16'd0;
    else if (frame_wrap)  frame_cnt <= frame_cnt + 16'd1;
  end

  assign o_FRAMECNT = frame_cnt;
`else
  assign o_FRAMECNT = 16'd0;
`endif

endmodule

// File: tb/tb_ika_video_timing.sv
// tb_ika_video_timing -- directed bench for ika_video_timing.
// u_dut_a uses the default geometry for pixel-level and first-line checks;
// u_dut_b uses a scaled-down raster (24x30 px, PXCEN_DIV=2) so several whole
// frames, mode switches and the VPOS wrap fit in a short run.
module tb_ika_video_timing;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode  = 2'd0;
  logic [1:0] adj_h = 2'd0;
  logic [2:0] adj_v = 3'd0;
  logic [3:0] vpos  = 4'd0;

  logic        a_pxcen, a_hs, a_vs, a_hb, a_vb;
  logic [8:0]  a_hcnt, a_vcnt;
  logic [15:0] a_fc;
  logic        b_pxcen, b_hs, b_vs, b_hb, b_vb;
  logic [8:0]  b_hcnt, b_vcnt;
  logic [15:0] b_fc;

`ifdef IKA_VTIMING_FRAMECNT_EN
  localparam logic [15:0] FC_AFTER3 = 16'd3;
`else
  localparam logic [15:0] FC_AFTER3 = 16'd0;
`endif

  always #5 clk = ~clk;

  ika_video_timing u_dut_a (
    .i_EMU_MCLK(clk), .i_EMU_INITRST_n(rst_n),
    .i_MODE(mode), .i_ADJ_H(adj_h), .i_ADJ_V(adj_v), .i_VPOS(vpos),
    .o_PXCEN(a_pxcen), .o_HCNT(a_hcnt), .o_VCNT(a_vcnt),
    .o_HSYNC_n(a_hs), .o_VSYNC_n(a_vs), .o_HBLANK_n(a_hb), .o_VBLANK_n(a_vb),
    .o_FRAMECNT(a_fc)
  );

  ika_video_timing #(
    .PXCEN_DIV(2), .CNT_W(9),
    .H_TOTAL(24), .H_ACTIVE(16), .H_SYNC_START(18), .H_SYNC_LEN(3),
    .V_TOTAL(30), .V_ACTIVE(20), .V_SYNC_START(22), .V_SYNC_LEN(3),
    .H_TOTAL_NTSC(24), .V_TOTAL_NTSC(28)
  ) u_dut_b (
    .i_EMU_MCLK(clk), .i_EMU_INITRST_n(rst_n),
    .i_MODE(mode), .i_ADJ_H(adj_h), .i_ADJ_V(adj_v), .i_VPOS(vpos),
    .o_PXCEN(b_pxcen), .o_HCNT(b_hcnt), .o_VCNT(b_vcnt),
    .o_HSYNC_n(b_hs), .o_VSYNC_n(b_vs), .o_HBLANK_n(b_hb), .o_VBLANK_n(b_vb),
    .o_FRAMECNT(b_fc)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rng(input int lo, input int hi);
    logic [511:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Master clock edge counter.
  int edges = 0;
  always @(posedge clk) edges++;

  // DUT A: collect which pixels of line 0 show hsync/hblank low.
  logic [511:0] a_hs_m, a_hb_m;
  always @(negedge clk) begin
    if (!rst_n) begin
      a_hs_m = '0;
      a_hb_m = '0;
    end else if (a_vcnt == 9'd0) begin
      if (!a_hs) a_hs_m[a_hcnt] = 1'b1;
      if (!a_hb) a_hb_m[a_hcnt] = 1'b1;
    end
  end

  // DUT B: one record per complete frame (start-to-start).
  typedef struct packed {
    logic [31:0] cycles;
    logic [31:0] htot;
    logic [31:0] vtot;
    logic [63:0] vs;
    logic [63:0] vb;
    logic [63:0] hs;
    logic [63:0] hb;
  } frame_t;

  frame_t frames[$];
  frame_t acc;
  bit     prev_zero, have_start;
  int     start_edge;

  always @(negedge clk) begin
    bit zero;
    if (!rst_n) begin
      prev_zero  = 1'b1;
      have_start = 1'b0;
      acc        = '0;
    end else begin
      zero = (b_hcnt == 9'd0) && (b_vcnt == 9'd0);
      if (zero && !prev_zero) begin
        if (have_start) begin
          acc.cycles = edges - start_edge;
          acc.htot   = acc.htot + 1;
          acc.vtot   = acc.vtot + 1;
          frames.push_back(acc);
        end
        have_start = 1'b1;
        start_edge = edges;
        acc        = '0;
      end
      if (32'(b_hcnt) > acc.htot) acc.htot = 32'(b_hcnt);
      if (32'(b_vcnt) > acc.vtot) acc.vtot = 32'(b_vcnt);
      if (!b_vs) acc.vs[b_vcnt[5:0]] = 1'b1;
      if (!b_vb) acc.vb[b_vcnt[5:0]] = 1'b1;
      if (!b_hs) acc.hs[b_hcnt[5:0]] = 1'b1;
      if (!b_hb) acc.hb[b_hcnt[5:0]] = 1'b1;
      prev_zero = zero;
    end
  end

  task automatic get_frame(output frame_t f);
    int t = 0;
    while (frames.size() == 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (frames.size() == 0) begin
      check("frame_timeout", 1, 0);
      f = '0;
    end else begin
      f = frames.pop_front();
    end
  endtask

  // Release reset on a falling edge and time the first pixel enables.
  task automatic release_and_time();
    int first_a = -1, second_a = -1, first_b = -1;
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (a_pxcen) begin
        if (first_a < 0) first_a = n;
        else if (second_a < 0) second_a = n;
      end
      if (b_pxcen && first_b < 0) first_b = n;
      if (n == 9) begin
        check("a_hcnt_pre_edge", a_hcnt, 0);
        check("a_sync_pre_edge", {a_hs, a_vs, a_hb, a_vb}, 4'hF);
      end
      if (n == 10) check("a_hcnt_first_step", a_hcnt, 1);
      @(negedge clk);
    end
    check("a_pxcen_first", first_a, 9);
    check("a_pxcen_second", second_a, 19);
    check("b_pxcen_first", first_b, 1);
  endtask

  task automatic wait_mid(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    frame_t f;
    int     rel_edge;
    int     t;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_a_pxcen", a_pxcen, 0);
    check("rst_a_cnt", {a_hcnt, a_vcnt}, 0);
    check("rst_a_sync", {a_hs, a_vs, a_hb, a_vb}, 4'hF);
    check("rst_a_fc", a_fc, 0);

    release_and_time();

    // First line of the default raster: 384 pixels of 10 clocks.
    rel_edge = edges - 40;
    t = 0;
    while (a_vcnt == 9'd0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("a_line_len", edges - rel_edge, 3840);
    check("a_hsync_pixels", a_hs_m, rng(296, 327));
    check("a_hblank_pixels", a_hb_m, rng(256, 383));

    // Original mode on the scaled raster.
    frames.delete();
    get_frame(f);
    check("b0_cycles", f.cycles, 1440);
    check("b0_htot", f.htot, 24);
    check("b0_vtot", f.vtot, 30);
    check("b0_vsync", f.vs, rng(22, 24));
    check("b0_vblank", f.vb, rng(20, 29));
    check("b0_hsync", f.hs, rng(18, 20));
    check("b0_hblank", f.hb, rng(16, 23));

    // Custom mode applied mid-frame: current frame unchanged, next is 30x35.
    wait_mid(300);
    mode = 2'd2; adj_h = 2'd3; adj_v = 3'd5;
    get_frame(f);
    check("b1_cycles_unchanged", f.cycles, 1440);
    get_frame(f);
    check("b2_htot_custom", f.htot, 30);
    check("b2_vtot_custom", f.vtot, 35);
    check("b2_cycles_custom", f.cycles, 2100);
    check("b2_hsync_custom", f.hs, rng(18, 20));
    check("b2_vblank_custom", f.vb, rng(20, 34));

    // NTSC-friendly mode.
    wait_mid(300);
    mode = 2'd1;
    get_frame(f);
    check("b3_vtot_still_custom", f.vtot, 35);
    get_frame(f);
    check("b4_htot_ntsc", f.htot, 24);
    check("b4_vtot_ntsc", f.vtot, 28);
    check("b4_cycles_ntsc", f.cycles, 1344);

    // VPOS=1 gives offset -7: vsync lines 15..17.
    wait_mid(300);
    mode = 2'd0; adj_h = 2'd0; adj_v = 3'd0; vpos = 4'd1;
    get_frame(f);
    get_frame(f);
    check("b6_vtot_orig", f.vtot, 30);
    check("b6_vsync_m7", f.vs, rng(15, 17));
    check("b6_vblank_m7", f.vb, rng(20, 29));

    // VPOS=15 gives +7: start 29, window wraps into lines 0 and 1.
    wait_mid(300);
    vpos = 4'd15;
    get_frame(f);
    get_frame(f);
    check("b9_vsync_wrap", f.vs, rng(0, 1) | rng(29, 29));
    check("b9_vblank_p7", f.vb, rng(20, 29));
    check("b9_hblank_p7", f.hb, rng(16, 23));
    check("b9_cycles", f.cycles, 1440);

    // Asynchronous reset mid-line at line 12.
    vpos = 4'd0;
    t = 0;
    while (!(b_vcnt == 9'd12 && b_hcnt == 9'd7) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("b_reached_line12", b_vcnt, 12);
    #2 rst_n = 1'b0;
    #1;
    check("arst_b_cnt", {b_hcnt, b_vcnt}, 0);
    check("arst_b_sync", {b_hs, b_vs, b_hb, b_vb}, 4'hF);
    check("arst_b_pxcen", b_pxcen, 0);
    check("arst_b_fc", b_fc, 0);
    check("arst_a_cnt", {a_hcnt, a_vcnt}, 0);
    @(negedge clk);
    @(negedge clk);

    frames.delete();
    release_and_time();
    get_frame(f);
    check("rr_b_cycles", f.cycles, 1440);
    get_frame(f);
    check("rr_b_fc_after3", b_fc, FC_AFTER3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
